imem_loader: RTL and testbench

Program loader that writes instruction memory for the neural-network processor. It accepts a byte stream over a valid/ready handshake and packs each group of four bytes into a 32-bit instruction word, first byte as bits 31:24 so the opcode arrives first. Each completed word is written to sequential instruction-memory addresses starting at 0. When the final word is stored, the block releases the processor to run; until then the processor is held.

---
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs big-endian bytes into instruction words,
// writes them to sequential instruction-memory addresses and releases the CPU when done.
module imem_loader #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [BUS_WIDTH-1:0]  imem_wdata,
  output logic                  cpu_run,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  error
);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;
  logic [BUS_WIDTH-1:0]  r_word;
  logic [1:0]            r_byte_cnt;
  logic                  r_last;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic w_accept;
  logic w_fourth;
  logic w_ptr_full;
  logic w_reload;

  assign w_accept   = in_valid && (r_state == S_LOAD);
  assign w_fourth   = (r_byte_cnt == 2'd3);
  assign w_ptr_full = &r_ptr;
  assign w_reload   = reload && ((r_state == S_DONE) || (r_state == S_ERR));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (w_fourth) begin
            w_state_next = S_WRITE;
          end else if (in_last) begin
            w_state_next = S_ERR;
          end
        end
      end
      S_WRITE: begin
        // End-of-program wins over a full memory: the last slot may hold the final word.
        if (r_last) begin
          w_state_next = S_DONE;
        end else if (w_ptr_full) begin
          w_state_next = S_ERR;
        end else begin
          w_state_next = S_LOAD;
        end
      end
      S_DONE: begin
        if (w_reload) begin
          w_state_next = S_LOAD;
        end
      end
      S_ERR: begin
        if (w_reload) begin
          w_state_next = S_LOAD;
        end
      end
      default: w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_word     <= '0;
      r_byte_cnt <= 2'd0;
      r_last     <= 1'b0;
      r_ptr      <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        if (w_fourth) begin
          r_word     <= {r_word[BUS_WIDTH-9:0], in_data};
          r_byte_cnt <= 2'd0;
          r_last     <= in_last;
        end else if (in_last) begin
          r_word     <= '0;
          r_byte_cnt <= 2'd0;
        end else begin
          r_word     <= {r_word[BUS_WIDTH-9:0], in_data};
          r_byte_cnt <= r_byte_cnt + 2'd1;
        end
      end
      if (r_state == S_WRITE) begin
        // The pointer parks at the top address; the count alone records the final commit.
        r_count <= r_count + CNT_ONE;
        if (!w_ptr_full) begin
          r_ptr <= r_ptr + PTR_ONE;
        end
      end
      if (w_reload) begin
        r_word     <= '0;
        r_byte_cnt <= 2'd0;
        r_last     <= 1'b0;
        r_ptr      <= '0;
        r_count    <= '0;
      end
    end
  end

  assign in_ready   = (r_state == S_LOAD);
  assign imem_we    = (r_state == S_WRITE);
  assign imem_addr  = r_ptr;
  assign imem_wdata = r_word;
  assign cpu_run    = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a transaction-level model predicts the words, addresses,
// final status and memory image from the byte list alone.
module tb_imem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          CLK;
  logic          RST;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic [AW:0]   word_count;
  logic          error;

  imem_loader #(.BUS_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .word_count(word_count), .error(error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mem     [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int          wlog_addr[$];
  logic [31:0] wlog_data[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory-side monitor: sampled mid-cycle, one line per committed write.
  always @(negedge CLK) begin
    if (imem_we) begin
      wlog_addr.push_back(int'(imem_addr));
      wlog_data.push_back(imem_wdata);
      mem[imem_addr] = imem_wdata;
      $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Called and returns on a falling edge; acc=1 when the byte was taken at a rising edge.
  task automatic send_byte(input logic [7:0] d, input bit l, input int gap_max,
                           input int bound, output bit acc);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) @(negedge CLK);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc      = 1'b0;
    for (int t = 0; t < bound; t++) begin
      if (in_ready) begin
        @(posedge CLK);
        acc = 1'b1;
        @(negedge CLK);
        break;
      end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
    chk("reload_ready", in_ready, 1);
    chk("reload_run", cpu_run, 0);
    chk("reload_err", error, 0);
    chk("reload_count", word_count, 0);
  endtask

  task automatic run_program(input logic [7:0] b[$], input bit l[$], input int gap_max);
    int          n_send;
    logic [31:0] ew[$];
    bit          exp_err;
    bit          exp_done;
    bit          acc;
    n_send   = b.size();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      if (i % 4 == 3) begin
        ew.push_back({b[i-3], b[i-2], b[i-1], b[i]});
        if (l[i]) begin exp_done = 1'b1; n_send = i + 1; break; end
        if (ew.size() == DEPTH) begin exp_err = 1'b1; n_send = i + 1; break; end
      end else if (l[i]) begin
        exp_err = 1'b1; n_send = i + 1; break;
      end
    end
    wlog_addr.delete();
    wlog_data.delete();
    for (int i = 0; i < n_send; i++) begin
      send_byte(b[i], l[i], gap_max, 20, acc);
      chk("byte_accepted", acc, 1);
      if (acc && (i % 4 == 3)) begin
        chk("we_after_4th", imem_we, 1);
        chk("addr_in_write", imem_addr, i / 4);
        chk("data_in_write", imem_wdata, ew[i/4]);
        chk("count_pre_commit", word_count, i / 4);
        chk("ready_in_write", in_ready, 0);
        chk("run_in_write", cpu_run, 0);
      end
    end
    repeat (2) @(negedge CLK);
    chk("write_total", wlog_addr.size(), ew.size());
    for (int k = 0; k < ew.size() && k < wlog_addr.size(); k++) begin
      chk("write_addr", wlog_addr[k], k);
      chk("write_data", wlog_data[k], ew[k]);
    end
    foreach (ew[k]) exp_mem[k] = ew[k];
    chk("word_count", word_count, ew.size());
    chk("cpu_run", cpu_run, exp_done);
    chk("error", error, exp_err);
    chk("in_ready", in_ready, !(exp_done || exp_err));
    for (int a = 0; a < DEPTH; a++) chk("mem_image", mem[a], exp_mem[a]);
    $display("program bytes=%0d words=%0d done=%0d err=%0d", n_send, ew.size(), exp_done, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b[$];
    bit         l[$];
    bit         acc;
    for (int a = 0; a < DEPTH; a++) begin mem[a] = '0; exp_mem[a] = '0; end
    RST = 1'b1;
    reload = 1'b0;
    idle_inputs();
    #3;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_err", error, 0);
    chk("rst_count", word_count, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_count", word_count, 0);

    // Basic single-word program.
    b = {8'h12, 8'h34, 8'h56, 8'h78}; l = {1'b0, 1'b0, 1'b0, 1'b1};
    run_program(b, l, 0);

    // Reload from DONE with a byte offered in the same cycle: that byte must be refused.
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b0;
    @(negedge CLK);
    reload = 1'b0;
    idle_inputs();
    chk("reload_valid_ready", in_ready, 1);
    chk("reload_valid_run", cpu_run, 0);
    chk("reload_valid_count", word_count, 0);
    b = {8'hC0, 8'hFF, 8'hEE, 8'h01}; l = {1'b0, 1'b0, 1'b0, 1'b1};
    run_program(b, l, 0);
    pulse_reload();

    // Two words with random gaps.
    b.delete(); l.delete();
    for (int i = 0; i < 8; i++) begin b.push_back(8'($urandom)); l.push_back(i == 7); end
    run_program(b, l, 3);
    pulse_reload();

    // Framing error: last on the third byte.
    b = {8'h01, 8'h02, 8'h03, 8'h04}; l = {1'b0, 1'b0, 1'b1, 1'b0};
    run_program(b, l, 1);
    pulse_reload();

    // Overflow, then the same bytes terminated on the final slot.
    b.delete(); l.delete();
    for (int i = 0; i < 16; i++) begin b.push_back(8'($urandom)); l.push_back(1'b0); end
    run_program(b, l, 1);
    send_byte(8'h5A, 1'b0, 0, 6, acc);
    chk("byte17_rejected", acc, 0);
    chk("overflow_err_hold", error, 1);
    pulse_reload();
    l[15] = 1'b1;
    run_program(b, l, 1);
    pulse_reload();

    // reload during LOAD is ignored: the partial word survives it.
    send_byte(8'h01, 1'b0, 0, 20, acc);
    send_byte(8'h02, 1'b0, 0, 20, acc);
    reload = 1'b1;
    @(negedge CLK);
    reload = 1'b0;
    send_byte(8'h03, 1'b0, 0, 20, acc);
    send_byte(8'h04, 1'b1, 0, 20, acc);
    chk("load_reload_we", imem_we, 1);
    chk("load_reload_addr", imem_addr, 0);
    chk("load_reload_data", imem_wdata, 32'h01020304);
    @(negedge CLK);
    exp_mem[0] = 32'h01020304;
    chk("load_reload_run", cpu_run, 1);
    pulse_reload();

    // Reset mid-word, then reset during a WRITE cycle.
    send_byte(8'h11, 1'b0, 0, 20, acc);
    send_byte(8'h22, 1'b0, 0, 20, acc);
    #1 RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 1'b0, 0, 20, acc);
    chk("midwrite_we_before", imem_we, 1);
    #1 RST = 1'b1;
    #1;
    chk("midwrite_we_abort", imem_we, 0);
    chk("midwrite_count", word_count, 0);
    @(negedge CLK);
    RST = 1'b0;
    b = {8'hAA, 8'hBB, 8'hCC, 8'hDD}; l = {1'b0, 1'b0, 1'b0, 1'b1};
    run_program(b, l, 0);
    pulse_reload();

    // Random programs: clean ends, framing errors and overflows.
    for (int p = 0; p < 25; p++) begin
      int len;
      int mode;
      b.delete(); l.delete();
      mode = int'($urandom_range(3, 0));
      len  = (mode == 0) ? 16 : int'($urandom_range(16, 1));
      for (int i = 0; i < len; i++) begin
        b.push_back(8'($urandom));
        l.push_back((mode != 0) && (i == len - 1));
      end
      run_program(b, l, 3);
      pulse_reload();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
